// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Types and constants shared by the UART receiver (uart_rx) and transmitter
// (uart_tx).
//
// Contents:
//   uart_state_e     frame state machine encoding (IDLE/START/DATA/PARITY/STOP)
//   CFG_* indices    bit positions of the fields inside the 5-bit cfg word
//   DATA_LEN_BASE    data-bit count for cfg[1:0]==2'b00 (5 bits)
//   calc_parity()    parity bit for a data word (even/odd)
// -----------------------------------------------------------------------------
package uart_pkg;

  // Frame state machine encoding
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } uart_state_e;

  // Field positions inside the configuration word
  localparam int CFG_DBITS_LSB   = 0;  // [1:0] data bits, 00=5 .. 11=8
  localparam int CFG_DBITS_MSB   = 1;
  localparam int CFG_STOP_BIT    = 2;  // 0 = 1 stop bit, 1 = 2 stop bits
  localparam int CFG_PAR_EN_BIT  = 3;  // 1 = parity bit present
  localparam int CFG_PAR_ODD_BIT = 4;  // 0 = even, 1 = odd

  localparam int CFG_WIDTH = 5;

  // Data-bit count encoded by cfg[1:0] == 2'b00
  localparam logic [3:0] DATA_LEN_BASE = 4'd5;

  // Parity bit that a transmitter appends to 'data'. Unused upper data bits
  // must be zero so they do not disturb the XOR.
  function automatic logic calc_parity(input logic [7:0] data, input logic odd);
    return (^data) ^ odd;
  endfunction

endpackage : uart_pkg

// File: rtl/uart_rx_sync.sv
// -----------------------------------------------------------------------------
// uart_rx_sync
// Two-flop synchronizer for the asynchronous serial input. Both flops reset
// to 1 so that a reset never looks like a start bit (line idles high).
//
// Ports:
//   clk      system clock
//   rst      asynchronous active-high reset
//   i_async  raw asynchronous serial line
//   o_sync   synchronized line (2 clk latency)
// -----------------------------------------------------------------------------
module uart_rx_sync (
  input  logic clk,
  input  logic rst,
  input  logic i_async,
  output logic o_sync
);

  logic r_meta;
  logic r_sync;

  // Two-stage metastability filter, idle-high reset value
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_meta <= 1'b1;
      r_sync <= 1'b1;
    end else begin
      r_meta <= i_async;
      r_sync <= r_meta;
    end
  end

  assign o_sync = r_sync;

endmodule : uart_rx_sync

// File: rtl/uart_rx.sv
// -----------------------------------------------------------------------------
// uart_rx
// UART receiver with 16x oversampling. Supports 5..8 data bits, 1 or 2 stop
// bits and an optional parity bit. The configuration is latched at the start
// of every frame, so cfg_reg may change freely while a frame is in flight.
//
// Build option:
//   UART_RX_PARITY_CHECK_EN  when defined, the parity bit is checked and
//                            reported on parity_err. When undefined, the
//                            parity bit time is still consumed but its value
//                            is ignored and parity_err is tied to 0.
//
// Ports:
//   clk          system clock, rising edge
//   rst          asynchronous active-high reset
//   baud_tick16  one-clk pulse at 16x the baud rate
//   rx_enable    allows new frames to start (a running frame always finishes)
//   cfg_reg      [1:0] data bits, [2] stop bits, [3] parity en, [4] odd parity
//   rx           asynchronous serial line, idle high
//   rx_data      received word, LSB-aligned, unused upper bits 0
//   rx_valid     one-clk pulse at the end of each frame
//   rx_busy      high whenever the receiver is not IDLE
//   parity_err   parity mismatch on the last frame
//   frame_err    a stop bit was sampled low on the last frame
// -----------------------------------------------------------------------------
module uart_rx
  import uart_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 baud_tick16,
  input  logic                 rx_enable,
  input  logic [CFG_WIDTH-1:0] cfg_reg,
  input  logic                 rx,
  output logic [7:0]           rx_data,
  output logic                 rx_valid,
  output logic                 rx_busy,
  output logic                 parity_err,
  output logic                 frame_err
);

  // Synchronized line and edge detection
  logic w_rx;
  logic w_fall;
  logic r_rx_prev;
  logic r_fall_pend;
  logic w_fall_pend_next;

  // Frame state and counters
  uart_state_e          r_state;
  uart_state_e          w_state_next;
  logic [3:0]           r_tick_cnt;
  logic [3:0]           w_tick_next;
  logic [3:0]           r_bit_cnt;
  logic [3:0]           w_bit_next;
  logic [CFG_WIDTH-1:0] r_cfg;
  logic [CFG_WIDTH-1:0] w_cfg_next;
  logic [7:0]           r_shift;
  logic [7:0]           w_shift_next;
  logic                 r_frm_pend;
  logic                 w_frm_pend_next;

  // Registered outputs
  logic [7:0] r_rx_data;
  logic [7:0] w_rx_data_next;
  logic       r_rx_valid;
  logic       w_rx_valid_next;
  logic       r_rx_busy;
  logic       r_frame_err;
  logic       w_frame_err_next;

`ifdef UART_RX_PARITY_CHECK_EN
  logic r_par_pend;
  logic w_par_pend_next;
  logic r_parity_err;
  logic w_parity_err_next;
`endif

  // Helpers derived from the latched configuration
  logic       w_centre;
  logic [3:0] w_last_data_idx;
  logic [3:0] w_last_stop_idx;

  uart_rx_sync u_sync (
    .clk     (clk),
    .rst     (rst),
    .i_async (rx),
    .o_sync  (w_rx)
  );

  assign w_fall          = r_rx_prev & ~w_rx;
  // Tick counter restarts at 0 on the start-bit centre, so tick 15 of every
  // following 16-tick window lands on the next bit centre.
  assign w_centre        = baud_tick16 & (r_tick_cnt == 4'd15);
  assign w_last_data_idx = {2'b00, r_cfg[CFG_DBITS_MSB:CFG_DBITS_LSB]} + DATA_LEN_BASE - 4'd1;
  assign w_last_stop_idx = {3'b000, r_cfg[CFG_STOP_BIT]};

  // Next-state and datapath logic for the frame state machine
  always_comb begin
    w_state_next     = r_state;
    w_tick_next      = r_tick_cnt;
    w_bit_next       = r_bit_cnt;
    w_cfg_next       = r_cfg;
    w_shift_next     = r_shift;
    w_frm_pend_next  = r_frm_pend;
    w_rx_data_next   = r_rx_data;
    w_rx_valid_next  = 1'b0;
    w_frame_err_next = r_frame_err;
`ifdef UART_RX_PARITY_CHECK_EN
    w_par_pend_next   = r_par_pend;
    w_parity_err_next = r_parity_err;
`endif

    case (r_state)
      ST_IDLE: begin
        // r_fall_pend recovers an edge that arrived in the clk we came back
        if (rx_enable && !w_rx && (w_fall || r_fall_pend)) begin
          w_state_next    = ST_START;
          w_tick_next     = 4'd0;
          w_bit_next      = 4'd0;
          w_cfg_next      = cfg_reg;
          w_shift_next    = 8'd0;
          w_frm_pend_next = 1'b0;
`ifdef UART_RX_PARITY_CHECK_EN
          w_par_pend_next = 1'b0;
`endif
        end else begin
          w_state_next = ST_IDLE;
        end
      end

      ST_START: begin
        if (baud_tick16) begin
          if (r_tick_cnt == 4'd7) begin
            w_tick_next = 4'd0;
            // Still low at the start-bit centre: genuine start; otherwise a
            // glitch, dropped without touching any output.
            if (!w_rx) begin
              w_state_next = ST_DATA;
            end else begin
              w_state_next = ST_IDLE;
            end
          end else begin
            w_tick_next = r_tick_cnt + 4'd1;
          end
        end else begin
          w_tick_next = r_tick_cnt;
        end
      end

      ST_DATA: begin
        if (baud_tick16) begin
          w_tick_next = r_tick_cnt + 4'd1;
        end else begin
          w_tick_next = r_tick_cnt;
        end
        if (w_centre) begin
          w_shift_next[r_bit_cnt[2:0]] = w_rx;
          if (r_bit_cnt == w_last_data_idx) begin
            w_bit_next = 4'd0;
            if (r_cfg[CFG_PAR_EN_BIT]) begin
              w_state_next = ST_PARITY;
            end else begin
              w_state_next = ST_STOP;
            end
          end else begin
            w_bit_next = r_bit_cnt + 4'd1;
          end
        end else begin
          w_bit_next = r_bit_cnt;
        end
      end

      ST_PARITY: begin
        if (baud_tick16) begin
          w_tick_next = r_tick_cnt + 4'd1;
        end else begin
          w_tick_next = r_tick_cnt;
        end
        if (w_centre) begin
          w_state_next = ST_STOP;
`ifdef UART_RX_PARITY_CHECK_EN
          if (w_rx != calc_parity(r_shift, r_cfg[CFG_PAR_ODD_BIT])) begin
            w_par_pend_next = 1'b1;
          end else begin
            w_par_pend_next = r_par_pend;
          end
`endif
        end else begin
          w_state_next = ST_PARITY;
        end
      end

      ST_STOP: begin
        if (baud_tick16) begin
          w_tick_next = r_tick_cnt + 4'd1;
        end else begin
          w_tick_next = r_tick_cnt;
        end
        if (w_centre) begin
          if (r_bit_cnt == w_last_stop_idx) begin
            // Final stop sample: publish the frame in this same clk
            w_state_next     = ST_IDLE;
            w_tick_next      = 4'd0;
            w_bit_next       = 4'd0;
            w_rx_data_next   = r_shift;
            w_frame_err_next = r_frm_pend | ~w_rx;
            w_rx_valid_next  = 1'b1;
`ifdef UART_RX_PARITY_CHECK_EN
            w_parity_err_next = r_par_pend;
`endif
          end else begin
            w_bit_next      = r_bit_cnt + 4'd1;
            w_frm_pend_next = r_frm_pend | ~w_rx;
          end
        end else begin
          w_bit_next = r_bit_cnt;
        end
      end

      default: begin
        w_state_next = ST_IDLE;
        w_tick_next  = 4'd0;
        w_bit_next   = 4'd0;
      end
    endcase

    // An edge coinciding with the return to IDLE is remembered for one clk
    if ((r_state != ST_IDLE) && (w_state_next == ST_IDLE) && w_fall) begin
      w_fall_pend_next = 1'b1;
    end else begin
      w_fall_pend_next = 1'b0;
    end
  end

  // State, counters, datapath and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_tick_cnt  <= 4'd0;
      r_bit_cnt   <= 4'd0;
      r_cfg       <= {CFG_WIDTH{1'b0}};
      r_shift     <= 8'd0;
      r_frm_pend  <= 1'b0;
      r_rx_prev   <= 1'b1;
      r_fall_pend <= 1'b0;
      r_rx_data   <= 8'd0;
      r_rx_valid  <= 1'b0;
      r_rx_busy   <= 1'b0;
      r_frame_err <= 1'b0;
`ifdef UART_RX_PARITY_CHECK_EN
      r_par_pend   <= 1'b0;
      r_parity_err <= 1'b0;
`endif
    end else begin
      r_state     <= w_state_next;
      r_tick_cnt  <= w_tick_next;
      r_bit_cnt   <= w_bit_next;
      r_cfg       <= w_cfg_next;
      r_shift     <= w_shift_next;
      r_frm_pend  <= w_frm_pend_next;
      r_rx_prev   <= w_rx;
      r_fall_pend <= w_fall_pend_next;
      r_rx_data   <= w_rx_data_next;
      r_rx_valid  <= w_rx_valid_next;
      r_rx_busy   <= (w_state_next != ST_IDLE);
      r_frame_err <= w_frame_err_next;
`ifdef UART_RX_PARITY_CHECK_EN
      r_par_pend   <= w_par_pend_next;
      r_parity_err <= w_parity_err_next;
`endif
    end
  end

  assign rx_data   = r_rx_data;
  assign rx_valid  = r_rx_valid;
  assign rx_busy   = r_rx_busy;
  assign frame_err = r_frame_err;
`ifdef UART_RX_PARITY_CHECK_EN
  assign parity_err = r_parity_err;
`else
  assign parity_err = 1'b0;
`endif

endmodule : uart_rx

// File: tb/tb_uart_rx.sv
// -----------------------------------------------------------------------------
// tb_uart_rx
// Self-checking bench for uart_rx. Frames are driven bit by bit with a 16x
// tick every 4 clks (one bit = 64 clks); the expected word and error flags
// are queued when a frame is driven and compared when rx_valid pulses.
// -----------------------------------------------------------------------------
module tb_uart_rx;

  logic       clk;
  logic       rst;
  logic       baud_tick16;
  logic       rx_enable;
  logic [4:0] cfg_reg;
  logic       rx;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_busy;
  logic       parity_err;
  logic       frame_err;

  typedef struct packed {
    logic [7:0] data;
    logic       perr;
    logic       ferr;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks   = 0;
  int   n_errors   = 0;
  int   valid_cnt  = 0;
  logic prev_valid = 1'b0;

  uart_rx dut (
    .clk         (clk),
    .rst         (rst),
    .baud_tick16 (baud_tick16),
    .rx_enable   (rx_enable),
    .cfg_reg     (cfg_reg),
    .rx          (rx),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .rx_busy     (rx_busy),
    .parity_err  (parity_err),
    .frame_err   (frame_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // 16x tick: one clk pulse every 4 clks
  initial begin
    int div;
    div = 0;
    baud_tick16 = 1'b0;
    forever begin
      @(negedge clk);
      div = (div + 1) % 4;
      baud_tick16 = (div == 0);
    end
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_bit();
    repeat (64) @(negedge clk);
  endtask

  // Drive one frame; par_flip inverts the parity bit, stop2_low drives the
  // second stop bit low. push=0 drives the frame without expecting output.
  task automatic send_frame(input logic [7:0] data, input logic [4:0] cfg,
                            input logic par_flip, input logic stop2_low, input bit push);
    int   len;
    logic p;
    exp_t e;
    len = int'(cfg[1:0]) + 5;
    p   = cfg[4] ^ par_flip;
    e.data = 8'd0;
    for (int i = 0; i < len; i++) begin
      e.data[i] = data[i];
      p = p ^ data[i];
    end
`ifdef UART_RX_PARITY_CHECK_EN
    e.perr = cfg[3] & par_flip;
`else
    e.perr = 1'b0;
`endif
    e.ferr = cfg[2] & stop2_low;
    if (push) sb_q.push_back(e);
    cfg_reg = cfg;
    rx = 1'b0;
    wait_bit();
    for (int i = 0; i < len; i++) begin
      rx = data[i];
      wait_bit();
    end
    if (cfg[3]) begin
      rx = p;
      wait_bit();
    end
    rx = 1'b1;
    wait_bit();
    if (cfg[2]) begin
      rx = ~stop2_low;
      wait_bit();
    end
    rx = 1'b1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check_val({tag, "_data"},  rx_data,    0);
    check_val({tag, "_valid"}, rx_valid,   0);
    check_val({tag, "_busy"},  rx_busy,    0);
    check_val({tag, "_perr"},  parity_err, 0);
    check_val({tag, "_ferr"},  frame_err,  0);
  endtask

  // Scoreboard: compare every rx_valid pulse against the oldest expectation
  always @(negedge clk) begin
    exp_t e;
    if (rx_valid === 1'b1) begin
      valid_cnt++;
      check_val("valid_pulse_width", prev_valid, 0);
      check_val("sb_nonempty", (sb_q.size() > 0), 1);
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        check_val("rx_data",    rx_data,    e.data);
        check_val("parity_err", parity_err, e.perr);
        check_val("frame_err",  frame_err,  e.ferr);
      end
    end
    prev_valid = rx_valid;
  end

  initial begin
    #5_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int vc;
    int waited;
    rst       = 1'b1;
    rx        = 1'b1;
    rx_enable = 1'b1;
    cfg_reg   = 5'b00000;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;
    repeat (70) @(negedge clk);

    // 8N1 0xA5
    send_frame(8'hA5, 5'b00011, 1'b0, 1'b0, 1'b1);
    repeat (32) @(negedge clk);

    // 7E1 0x35 with correct, then wrong parity bit
    send_frame(8'h35, 5'b01010, 1'b0, 1'b0, 1'b1);
    repeat (32) @(negedge clk);
    send_frame(8'h35, 5'b01010, 1'b1, 1'b0, 1'b1);
    repeat (32) @(negedge clk);

    // 5N2 0x1F with second stop bit low
    send_frame(8'h1F, 5'b00100, 1'b0, 1'b1, 1'b1);
    repeat (96) @(negedge clk);

    // Short low glitch (4 tick16 periods)
    vc = valid_cnt;
    rx = 1'b0;
    repeat (8) @(negedge clk);
    check_val("glitch_busy_high", rx_busy, 1);
    repeat (8) @(negedge clk);
    rx = 1'b1;
    repeat (64) @(negedge clk);
    check_val("glitch_busy_low", rx_busy, 0);
    check_val("glitch_no_valid", valid_cnt - vc, 0);

    // Reset in the middle of the 4th data bit of an 8N1 frame (data 0xC3)
    vc = valid_cnt;
    cfg_reg = 5'b00011;
    rx = 1'b0;
    wait_bit();
    rx = 1'b1; wait_bit();
    rx = 1'b1; wait_bit();
    rx = 1'b0; wait_bit();
    rx = 1'b0;
    repeat (32) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_reset_outputs("midrst");
    rx = 1'b1;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    repeat (64) @(negedge clk);
    check_val("midrst_no_valid", valid_cnt - vc, 0);

    // Clean frame after reset, and data hold afterwards
    send_frame(8'h3C, 5'b00011, 1'b0, 1'b0, 1'b1);
    repeat (200) @(negedge clk);
    check_val("data_hold", rx_data, 8'h3C);

    // Back-to-back 8O1 frames
    vc = valid_cnt;
    send_frame(8'h00, 5'b11011, 1'b0, 1'b0, 1'b1);
    send_frame(8'hFF, 5'b11011, 1'b0, 1'b0, 1'b1);
    repeat (32) @(negedge clk);
    check_val("b2b_valid_count", valid_cnt - vc, 2);

    // Receiver disabled: frame must be ignored
    vc = valid_cnt;
    rx_enable = 1'b0;
    send_frame(8'h5A, 5'b00011, 1'b0, 1'b0, 1'b0);
    repeat (64) @(negedge clk);
    check_val("disabled_no_valid", valid_cnt - vc, 0);
    check_val("disabled_busy", rx_busy, 0);
    rx_enable = 1'b1;

    // Drain scoreboard with a bounded wait
    waited = 0;
    while (sb_q.size() != 0 && waited < 2000) begin
      @(negedge clk);
      waited++;
    end
    check_val("sb_drained", sb_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule : tb_uart_rx

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have port clk, input, 1, single system clock; all state updates on rising edge.
REQ-002 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-003 SHALL have port baud_tick16, input, 1, one-clk pulse at 16x the baud rate.
REQ-004 SHALL have port rx_enable, input, 1; when low, the receiver stays in or returns to IDLE only after the current frame ends.
REQ-005 SHALL have port cfg_reg, input, 5, with fields [1:0] data bits (00=5 .. 11=8), [2] stop bits (0=1, 1=2), [3] parity enable, [4] parity type (0=even, 1=odd).
REQ-006 SHALL have port rx, input, 1, asynchronous serial line, idle high.
REQ-007 SHALL have port rx_data, output, 8, received word, LSB-aligned, unused upper bits 0.
REQ-008 SHALL have port rx_valid, output, 1, one-clk pulse when a frame completes.
REQ-009 SHALL have port rx_busy, output, 1, high in every state except IDLE.
REQ-010 SHALL have port parity_err, output, 1, parity mismatch on the last frame.
REQ-011 SHALL have port frame_err, output, 1, a stop bit was sampled low on the last frame.

Function
REQ-012 SHALL pass rx through a 2-flop synchronizer before any use; this adds 2 clk of latency.
REQ-013 SHALL implement states IDLE, START, DATA, PARITY, STOP, with a 4-bit tick counter and a 4-bit bit counter.
REQ-014 In IDLE with rx_enable=1, a synchronized 1->0 transition SHALL move to START, clear the tick counter, and latch cfg_reg for the whole frame.
REQ-015 In START, on the 8th baud_tick16 (tick count 7), if the line is low SHALL go to DATA and clear the tick counter; if high, SHALL count a glitch and return to IDLE with no outputs changed.
REQ-016 In DATA, SHALL sample on every 16th baud_tick16 (bit centre) and shift samples LSB first; after (cfg[1:0]+5) bits SHALL go to PARITY if parity is enabled, else to STOP.
REQ-017 PARITY SHALL sample one bit and compare it with XOR of the received data bits (inverted when odd parity); a mismatch sets a pending parity error.
REQ-018 STOP SHALL sample 1 or 2 stop bits at centre; any low sample sets a pending frame error.
REQ-019 On the last stop sample, in the same clk, SHALL load rx_data, parity_err and frame_err, pulse rx_valid for exactly 1 clk, and return to IDLE.
REQ-020 rx_data, parity_err and frame_err SHALL hold their values until the next rx_valid.
REQ-021 A frame with frame_err SHALL still assert rx_valid; the data is delivered as sampled.
REQ-022 A falling edge seen in the same clk as the return to IDLE SHALL be detected on the next clk and SHALL NOT be lost, provided the line is still low.
REQ-023 Clearing rx_enable mid-frame SHALL NOT abort the frame.
REQ-024 baud_tick16 gaps SHALL stall all counters; there is no timeout.

Reset
REQ-025 While rst is high: state=IDLE, counters=0, rx_data=0, rx_valid=0, rx_busy=0, parity_err=0, frame_err=0, and synchronizer flops=1.
REQ-026 Reset asserted mid-frame SHALL discard the partial frame and produce no rx_valid.

Configuration
REQ-027 With macro UART_RX_PARITY_CHECK_EN defined, PARITY state and parity_err SHALL behave per REQ-017.
REQ-028 Without UART_RX_PARITY_CHECK_EN, the PARITY state SHALL still consume one bit time when cfg[3]=1, parity_err SHALL be tied to 0, and no parity logic SHALL be synthesized.

Structure
REQ-029 Package uart_pkg SHALL hold the state enum, cfg field index constants, and the data-length base (5); uart_tx and uart_rx share it.
REQ-030 The synchronizer SHALL be sub-module uart_rx_sync (2 flops, reset value 1); there is no other sub-module.

Verification
REQ-031 8N1, byte 0xA5 at 16x ticks -> one rx_valid, rx_data=0xA5, both errors 0.
REQ-032 7E1, data 0x35 with correct parity bit 0 -> rx_data=0x35, parity_err=0; the same frame with parity bit 1 -> parity_err=1 (macro on) or 0 (macro off).
REQ-033 5N2, data 0x1F with second stop bit low -> rx_valid, rx_data=0x1F, frame_err=1.
REQ-034 Low pulse of 4 tick16 periods on an idle line -> no rx_valid, rx_busy drops back to 0.
REQ-035 Reset raised during the 4th data bit of an 8N1 frame -> all outputs at reset values; the next clean frame 0x3C is received correctly.
REQ-036 Two back-to-back 8O1 frames 0x00 and 0xFF with no idle gap -> two rx_valid pulses, the correct data for each, and no errors.
